cr_huf_comp_lut_nbank: RTL and testbench

CR_HUF_COMP_LUT_NBANK -- requirements
Module: cr_huf_comp_lut_nbank

---
 rtl/cr_huf_comp_lut_nbank_pkg.sv | 17 +
 rtl/cr_huf_comp_lut_nbank_if.sv | 40 ++++
 rtl/cr_huf_comp_lut_nbank_ram.sv | 36 +++
 rtl/cr_huf_comp_lut_nbank.sv | 124 ++++++++++++
 tb/tb_cr_huf_comp_lut_nbank.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cr_huf_comp_lut_nbank_pkg.sv
// Shared types for the multi-bank Huffman code lookup table.
// Holds the bank state encoding and a width helper.
package cr_huf_compPKG;

  typedef enum logic [1:0] {
    BANK_FREE  = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_READY = 2'd2,
    BANK_DRAIN = 2'd3
  } bank_st_e;

  // Minimum width is 1 so that two-entry spaces still get a real index bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cr_huf_comp_lut_nbank_if.sv
// Table write/read bus for cr_huf_comp_lut_nbank.
// The master side is the table producer and consumer. The slave side is the LUT.
interface cr_huf_comp_lut_nbank_if #(
  parameter int NUM_BANKS = 2,
  parameter int DEPTH     = 64,
  parameter int DATA_W    = 32,
  parameter int SEQID_W   = 4
);
  import cr_huf_compPKG::*;
  localparam int AW = clog2w(DEPTH);
  localparam int CW = clog2w(NUM_BANKS) + 1;

  logic               wr_vld;
  logic [AW-1:0]      wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [SEQID_W-1:0] wr_seq_id;
  logic               wr_done;
  logic               wr_full;
  logic               rd_req;
  logic [AW-1:0]      rd_addr;
  logic [SEQID_W-1:0] rd_seq_id;
  logic               rd_ack;
  logic               rd_data_vld;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_miss;
  logic [CW-1:0]      ready_cnt;
  logic               wr_ovfl_err;

  modport master (
    output wr_vld, wr_addr, wr_data, wr_seq_id, wr_done,
    output rd_req, rd_addr, rd_seq_id, rd_ack,
    input  wr_full, rd_data_vld, rd_data, rd_miss, ready_cnt, wr_ovfl_err
  );

  modport slave (
    input  wr_vld, wr_addr, wr_data, wr_seq_id, wr_done,
    input  rd_req, rd_addr, rd_seq_id, rd_ack,
    output wr_full, rd_data_vld, rd_data, rd_miss, ready_cnt, wr_ovfl_err
  );
endinterface

// File: rtl/cr_huf_comp_lut_nbank_ram.sv
// Storage for one table bank: one write port and one registered read port.
// Each entry has a valid bit, so a clear empties the whole bank in a single cycle.
module cr_huf_comp_lut_nbank_ram
  import cr_huf_compPKG::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int AW     = clog2w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  input  logic              clr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Valid bits gate the data, so entries never written read back as zero.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   vld <= '0;
    else if (clr) vld <= '0;
    else if (we)  vld[waddr] <= 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= vld[raddr] ? mem[raddr] : '0;

endmodule

// File: rtl/cr_huf_comp_lut_nbank.sv
// N-bank ping-pong Huffman code lookup table.
// Tables are filled in the bank at wp and read from the bank at rp. Each bank is tagged with a sequence id.
module cr_huf_comp_lut_nbank
  import cr_huf_compPKG::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int DEPTH     = 64,
  parameter int DATA_W    = 32,
  parameter int SEQID_W   = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  cr_huf_comp_lut_nbank_if.slave bus
);
  localparam int BW = clog2w(NUM_BANKS);
  localparam int CW = BW + 1;
  localparam logic [BW-1:0] LAST = BW'(NUM_BANKS - 1);

  bank_st_e           st_q  [NUM_BANKS];
  bank_st_e           st_d  [NUM_BANKS];
  logic [SEQID_W-1:0] seq_q [NUM_BANKS];
  logic [SEQID_W-1:0] seq_d [NUM_BANKS];
  logic [BW-1:0]      wp_q, wp_d, rp_q, rp_d, sel_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovfl_q, ovfl_d, vld_q, hit_q;
  logic               full, hit, rel, inc, dec;
  logic [NUM_BANKS-1:0]             we, re, clr;
  logic [NUM_BANKS-1:0][DATA_W-1:0] rdata;

  function automatic logic occupied(input bank_st_e s);
    return (s == BANK_READY) || (s == BANK_DRAIN);
  endfunction

  always_comb begin
    st_d   = st_q;
    seq_d  = seq_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    we     = '0;
    re     = '0;
    clr    = '0;
    inc    = 1'b0;
    dec    = 1'b0;
    full   = occupied(st_q[wp_q]);
    hit    = bus.rd_req && occupied(st_q[rp_q]) && (seq_q[rp_q] == bus.rd_seq_id);
    rel    = bus.rd_ack && occupied(st_q[rp_q]);
    ovfl_d = ovfl_q | (full & (bus.wr_vld | bus.wr_done));
    re[rp_q] = bus.rd_req;

    if (hit && st_q[rp_q] == BANK_READY) st_d[rp_q] = BANK_DRAIN;
    // The read this cycle has already latched the bank, so it can be released in the same cycle.
    if (rel) begin
      st_d[rp_q] = BANK_FREE;
      clr[rp_q]  = 1'b1;
      rp_d       = (rp_q == LAST) ? '0 : rp_q + BW'(1);
      dec        = 1'b1;
    end

    // A bank at rp is never writable while occupied, so these writes never hit the bank just released.
    if (!full) begin
      if (bus.wr_vld) begin
        we[wp_q] = 1'b1;
        if (st_q[wp_q] == BANK_FREE) begin
          st_d[wp_q]  = BANK_FILL;
          seq_d[wp_q] = bus.wr_seq_id;
        end
      end
      if (bus.wr_done) begin
        if (st_q[wp_q] == BANK_FREE) seq_d[wp_q] = bus.wr_seq_id;
        st_d[wp_q] = BANK_READY;
        wp_d       = (wp_q == LAST) ? '0 : wp_q + BW'(1);
        inc        = 1'b1;
      end
    end
    cnt_d = cnt_q + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        st_q[b]  <= BANK_FREE;
        seq_q[b] <= '0;
      end
      wp_q   <= '0;
      rp_q   <= '0;
      sel_q  <= '0;
      cnt_q  <= '0;
      ovfl_q <= 1'b0;
      vld_q  <= 1'b0;
      hit_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      seq_q  <= seq_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      sel_q  <= rp_q;
      cnt_q  <= cnt_d;
      ovfl_q <= ovfl_d;
      vld_q  <= bus.rd_req;
      hit_q  <= hit;
    end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    cr_huf_comp_lut_nbank_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[b]),
      .waddr (bus.wr_addr),
      .wdata (bus.wr_data),
      .re    (re[b]),
      .raddr (bus.rd_addr),
      .clr   (clr[b]),
      .rdata (rdata[b])
    );
  end

  assign bus.wr_full     = full;
  assign bus.rd_data_vld = vld_q;
  assign bus.rd_miss     = vld_q & ~hit_q;
  assign bus.rd_data     = hit_q ? rdata[sel_q] : '0;
  assign bus.ready_cnt   = cnt_q;
  assign bus.wr_ovfl_err = ovfl_q;

endmodule

// File: tb/tb_cr_huf_comp_lut_nbank.sv
// Bench for cr_huf_comp_lut_nbank: directed vector table on a 2-bank build,
// hand sequences on a 4-bank build, and random traffic checked against a bank-level model.
module tb_cr_huf_comp_lut_nbank;

  typedef struct packed {
    logic wv; logic [3:0] wa; logic [31:0] wd; logic [3:0] ws; logic wdn;
    logic rq; logic [3:0] ra; logic [3:0] rs; logic ack;
  } stim_t;

  typedef struct {
    logic full, dv, miss, ovfl; logic [31:0] d; int rc;
  } obs_t;

  typedef struct {
    stim_t s; logic full; int rc; logic ovfl, dv, miss; logic [31:0] d;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  stim_t cur [2];
  int    n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  cr_huf_comp_lut_nbank_if #(.NUM_BANKS(2), .DEPTH(16), .DATA_W(32), .SEQID_W(4)) b2 ();
  cr_huf_comp_lut_nbank_if #(.NUM_BANKS(4), .DEPTH(16), .DATA_W(32), .SEQID_W(4)) b4 ();

  cr_huf_comp_lut_nbank #(.NUM_BANKS(2), .DEPTH(16), .DATA_W(32), .SEQID_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));
  cr_huf_comp_lut_nbank #(.NUM_BANKS(4), .DEPTH(16), .DATA_W(32), .SEQID_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave));

  assign b2.wr_vld = cur[0].wv;  assign b2.wr_addr = cur[0].wa;  assign b2.wr_data = cur[0].wd;
  assign b2.wr_seq_id = cur[0].ws; assign b2.wr_done = cur[0].wdn; assign b2.rd_req = cur[0].rq;
  assign b2.rd_addr = cur[0].ra; assign b2.rd_seq_id = cur[0].rs; assign b2.rd_ack = cur[0].ack;
  assign b4.wr_vld = cur[1].wv;  assign b4.wr_addr = cur[1].wa;  assign b4.wr_data = cur[1].wd;
  assign b4.wr_seq_id = cur[1].ws; assign b4.wr_done = cur[1].wdn; assign b4.rd_req = cur[1].rq;
  assign b4.rd_addr = cur[1].ra; assign b4.rd_seq_id = cur[1].rs; assign b4.rd_ack = cur[1].ack;

  // Model: bank phase 0 free, 1 filling, 2 ready, 3 draining
  int          m_st  [2][4];
  int          m_seq [2][4];
  logic [31:0] m_mem [2][4][16];
  int          m_wp [2], m_rp [2], m_rc [2];
  logic        m_ovfl [2], e_dv [2], e_miss [2];
  logic [31:0] e_d [2];

  function automatic int nbanks(int k); return k ? 4 : 2; endfunction

  function automatic logic m_full(int k); return m_st[k][m_wp[k]] >= 2; endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 4; b++) begin
        m_st[k][b] = 0; m_seq[k][b] = 0;
        for (int a = 0; a < 16; a++) m_mem[k][b][a] = '0;
      end
      m_wp[k] = 0; m_rp[k] = 0; m_rc[k] = 0;
      m_ovfl[k] = 0; e_dv[k] = 0; e_miss[k] = 0; e_d[k] = '0;
    end
  endtask

  task automatic model_step(int k, stim_t s);
    logic full, hit;
    int r, w;
    r = m_rp[k]; w = m_wp[k];
    full = m_full(k);
    e_dv[k] = s.rq; e_miss[k] = 0; e_d[k] = '0;
    if (s.rq) begin
      hit = (m_st[k][r] >= 2) && (m_seq[k][r] == int'(s.rs));
      e_miss[k] = !hit;
      if (hit) begin
        e_d[k] = m_mem[k][r][s.ra];
        m_st[k][r] = 3;
      end
    end
    if (s.ack && m_st[k][r] >= 2) begin
      m_st[k][r] = 0;
      for (int a = 0; a < 16; a++) m_mem[k][r][a] = '0;
      m_rp[k] = (r + 1) % nbanks(k);
      m_rc[k]--;
    end
    if (full) begin
      if (s.wv || s.wdn) m_ovfl[k] = 1;
    end else begin
      if (s.wv) begin
        if (m_st[k][w] == 0) begin m_st[k][w] = 1; m_seq[k][w] = int'(s.ws); end
        m_mem[k][w][s.wa] = s.wd;
      end
      if (s.wdn) begin
        if (m_st[k][w] == 0) m_seq[k][w] = int'(s.ws);
        m_st[k][w] = 2;
        m_wp[k] = (w + 1) % nbanks(k);
        m_rc[k]++;
      end
    end
  endtask

  function automatic obs_t get_obs(int k);
    obs_t o;
    if (k == 0) begin
      o.full = b2.wr_full; o.dv = b2.rd_data_vld; o.miss = b2.rd_miss;
      o.ovfl = b2.wr_ovfl_err; o.d = b2.rd_data; o.rc = int'(b2.ready_cnt);
    end else begin
      o.full = b4.wr_full; o.dv = b4.rd_data_vld; o.miss = b4.rd_miss;
      o.ovfl = b4.wr_ovfl_err; o.d = b4.rd_data; o.rc = int'(b4.ready_cnt);
    end
    return o;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic stim_t S(bit wv, int wa, int wd, int ws, bit wdn, bit rq, int ra, int rs, bit ack);
    stim_t s;
    s.wv = wv; s.wa = 4'(wa); s.wd = 32'(wd); s.ws = 4'(ws); s.wdn = wdn;
    s.rq = rq; s.ra = 4'(ra); s.rs = 4'(rs); s.ack = ack;
    return s;
  endfunction

  function automatic vec_t V(stim_t s, bit full, int rc, bit ovfl, bit dv, bit miss, int d);
    vec_t v;
    v.s = s; v.full = full; v.rc = rc; v.ovfl = ovfl; v.dv = dv; v.miss = miss; v.d = 32'(d);
    return v;
  endfunction

  task automatic cyc_pre(int k, stim_t s);
    @(negedge clk);
    cur[k] = s;
    model_step(k, s);
  endtask

  task automatic cyc_post(int k, string tag);
    obs_t o;
    @(posedge clk); #1;
    cur[k] = '0;
    o = get_obs(k);
    chk({tag, " wr_full"}, o.full, m_full(k));
    chk({tag, " ready_cnt"}, o.rc, m_rc[k]);
    chk({tag, " ovfl"}, o.ovfl, m_ovfl[k]);
    chk({tag, " rd_vld"}, o.dv, e_dv[k]);
    chk({tag, " rd_miss"}, o.miss, e_miss[k]);
    chk({tag, " rd_data"}, o.d, e_d[k]);
  endtask

  task automatic cycle(int k, stim_t s, string tag);
    cyc_pre(k, s);
    cyc_post(k, tag);
  endtask

  task automatic reset_checks(string tag);
    obs_t o;
    for (int k = 0; k < 2; k++) begin
      o = get_obs(k);
      chk($sformatf("%s k%0d full", tag, k), o.full, 0);
      chk($sformatf("%s k%0d vld", tag, k), o.dv, 0);
      chk($sformatf("%s k%0d miss", tag, k), o.miss, 0);
      chk($sformatf("%s k%0d data", tag, k), o.d, 0);
      chk($sformatf("%s k%0d cnt", tag, k), o.rc, 0);
      chk($sformatf("%s k%0d ovfl", tag, k), o.ovfl, 0);
    end
  endtask

  initial begin
    vec_t  tbl [$];
    obs_t  o;
    stim_t s;

    cur[0] = '0; cur[1] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_checks("reset");
    @(negedge clk) rst_n = 1'b1;

    // Expected outputs one cycle after each row is applied (2 banks)
    tbl.push_back(V(S(1,5,'hA5A5,3,0,0,0,0,0), 0,0,0,0,0,0));
    tbl.push_back(V(S(1,1,'h1111,7,0,0,0,0,0), 0,0,0,0,0,0));
    tbl.push_back(V(S(0,0,0,0,1,0,0,0,0),      0,1,0,0,0,0));
    tbl.push_back(V(S(0,0,0,0,0,1,5,3,0),      0,1,0,1,0,'hA5A5));
    tbl.push_back(V(S(0,0,0,0,0,1,5,4,0),      0,1,0,1,1,0));
    tbl.push_back(V(S(0,0,0,0,0,1,2,3,0),      0,1,0,1,0,0));
    tbl.push_back(V(S(0,0,0,0,0,1,1,3,0),      0,1,0,1,0,'h1111));
    tbl.push_back(V(S(1,0,'hBEEF,9,1,0,0,0,0), 1,2,0,0,0,0));
    tbl.push_back(V(S(1,3,'h1234,1,0,0,0,0,0), 1,2,1,0,0,0));
    tbl.push_back(V(S(0,0,0,0,0,1,0,9,0),      1,2,1,1,1,0));
    tbl.push_back(V(S(0,0,0,0,0,1,5,3,1),      0,1,1,1,0,'hA5A5));
    tbl.push_back(V(S(0,0,0,0,0,1,0,9,0),      0,1,1,1,0,'hBEEF));
    tbl.push_back(V(S(0,0,0,0,0,1,5,3,1),      0,0,1,1,1,0));
    tbl.push_back(V(S(0,0,0,0,0,1,5,3,0),      0,0,1,1,1,0));
    tbl.push_back(V(S(0,0,0,6,1,0,0,0,0),      0,1,1,0,0,0));
    tbl.push_back(V(S(0,0,0,0,0,1,5,6,0),      0,1,1,1,0,0));
    tbl.push_back(V(S(0,0,0,0,0,0,0,0,1),      0,0,1,0,0,0));
    tbl.push_back(V(S(0,0,0,0,0,0,0,0,1),      0,0,1,0,0,0));
    tbl.push_back(V(S(1,2,'h77,2,0,0,0,0,0),   0,0,1,0,0,0));
    tbl.push_back(V(S(0,0,0,0,0,1,2,2,0),      0,0,1,1,1,0));
    tbl.push_back(V(S(0,0,0,0,1,0,0,0,0),      0,1,1,0,0,0));
    tbl.push_back(V(S(0,0,0,0,0,1,2,2,0),      0,1,1,1,0,'h77));
    tbl.push_back(V(S(0,0,0,0,0,0,0,0,1),      0,0,1,0,0,0));

    foreach (tbl[i]) begin
      cycle(0, tbl[i].s, $sformatf("vec%0d model", i));
      o = get_obs(0);
      chk($sformatf("vec%0d full", i), o.full, tbl[i].full);
      chk($sformatf("vec%0d cnt", i), o.rc, tbl[i].rc);
      chk($sformatf("vec%0d ovfl", i), o.ovfl, tbl[i].ovfl);
      chk($sformatf("vec%0d vld", i), o.dv, tbl[i].dv);
      chk($sformatf("vec%0d miss", i), o.miss, tbl[i].miss);
      chk($sformatf("vec%0d data", i), o.d, tbl[i].d);
    end

    // 4 banks: fill all of them, then read and ack each one while rp wraps around
    for (int i = 0; i < 4; i++) cycle(1, S(1, i, 100 + i, i + 1, 1, 0, 0, 0, 0), $sformatf("fill%0d", i));
    o = get_obs(1);
    chk("nb4 full after fill", o.full, 1);
    chk("nb4 cnt after fill", o.rc, 4);
    for (int i = 0; i < 4; i++) begin
      cyc_pre(1, S(0, 0, 0, 0, 0, 1, i, i + 1, 1));
      if (i == 0) begin
        #1 chk("nb4 full during first ack", b4.wr_full, 1);
      end
      cyc_post(1, $sformatf("ack%0d", i));
      o = get_obs(1);
      chk($sformatf("nb4 ack%0d data", i), o.d, 100 + i);
      chk($sformatf("nb4 ack%0d miss", i), o.miss, 0);
      chk($sformatf("nb4 ack%0d cnt", i), o.rc, 3 - i);
      chk($sformatf("nb4 ack%0d full", i), o.full, 0);
    end
    cycle(1, S(1, 7, 'h55, 5, 1, 0, 0, 0, 0), "wrap fill");
    cycle(1, S(0, 0, 0, 0, 0, 1, 7, 5, 0), "wrap read");
    o = get_obs(1);
    chk("nb4 wrap data", o.d, 'h55);
    chk("nb4 wrap miss", o.miss, 0);

    // Reset while a table is half written and a read is being issued
    cycle(1, S(1, 1, 9, 2, 0, 0, 0, 0, 0), "pre-reset fill");
    @(negedge clk);
    cur[1] = S(1, 2, 8, 2, 0, 1, 1, 2, 0);
    #2 rst_n = 1'b0;
    #1 reset_checks("mid reset");
    cur[1] = '0;
    model_reset();
    @(posedge clk); #1 reset_checks("held reset");
    @(negedge clk) rst_n = 1'b1;
    cycle(1, S(0, 0, 0, 0, 0, 1, 1, 2, 0), "post reset read");
    o = get_obs(1);
    chk("post reset miss", o.miss, 1);
    chk("post reset data", o.d, 0);

    // Random traffic on both builds
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 1500; n++) begin
        s = '0;
        s.wv  = ($urandom_range(0, 99) < 40);
        s.wa  = 4'($urandom_range(0, 15));
        s.wd  = $urandom;
        s.ws  = 4'($urandom_range(0, 2));
        s.wdn = ($urandom_range(0, 99) < 15);
        s.rq  = ($urandom_range(0, 99) < 45);
        s.ra  = 4'($urandom_range(0, 15));
        s.rs  = 4'($urandom_range(0, 2));
        s.ack = ($urandom_range(0, 99) < 12);
        cycle(k, s, $sformatf("rnd k%0d n%0d", k, n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
